// File: rtl/timer_counter.sv
// Memory-mapped programmable down-counter with CTRL/PRESET/COUNT registers and a registered IRQ.
// Define TC_AUTORELOAD_EN to implement MODE 01 auto-reload; otherwise every mode is one-shot.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        pend_q, pend_d;
    logic        irq_q, irq_d;
    logic [1:0]  mode_rd;
    logic        reload;
    logic        ctrl_wr, preset_wr;

    // The bridge decodes the window; only the word select matters here.
    logic        unused_addr;
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    assign ctrl_wr   = WE && (Addr[3:2] == 2'b00);
    assign preset_wr = WE && (Addr[3:2] == 2'b01);

`ifdef TC_AUTORELOAD_EN
    logic [1:0] mode_q, mode_d;
    assign mode_rd = mode_q;
    assign reload  = (mode_q == 2'b01);
    always_comb begin
        mode_d = mode_q;
        if (ctrl_wr) mode_d = Din[2:1];
    end
`else
    assign mode_rd = 2'b00;
    assign reload  = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        en_d     = en_q;
        im_d     = im_q;
        preset_d = preset_q;
        count_d  = count_q;
        pend_d   = pend_q;

        case (state_q)
            S_IDLE: begin
                if (en_q) state_d = S_LOAD;
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!en_q) begin
                    state_d = S_IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d = '0;
                    pend_d  = 1'b1;
                    state_d = S_INT;
                end
            end
            S_INT: begin
                if (reload) begin
                    pend_d  = 1'b0;
                    state_d = S_LOAD;
                end else begin
                    en_d    = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // CPU writes are applied after the hardware updates so they win a same-cycle clash.
        if (ctrl_wr) begin
            en_d   = Din[0];
            im_d   = Din[3];
            pend_d = 1'b0;
        end
        if (preset_wr) preset_d = Din;

        irq_d = im_d & pend_d;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            en_q     <= 1'b0;
            im_q     <= 1'b0;
            preset_q <= '0;
            count_q  <= '0;
            pend_q   <= 1'b0;
            irq_q    <= 1'b0;
`ifdef TC_AUTORELOAD_EN
            mode_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            im_q     <= im_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            pend_q   <= pend_d;
            irq_q    <= irq_d;
`ifdef TC_AUTORELOAD_EN
            mode_q   <= mode_d;
`endif
        end
    end

    assign IRQ = irq_q;

    always_comb begin
        Dout = '0;
        case (Addr[3:2])
            2'b00:   Dout = {28'd0, im_q, mode_rd, en_q};
            2'b01:   Dout = preset_q;
            2'b10:   Dout = count_q;
            default: Dout = '0;
        endcase
    end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; expected values are hand-derived edge counts.
module tb_timer_counter;

    logic        clk;
    logic        reset;
    logic [31:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int n_cmp;
    int n_err;

    timer_counter dut (
        .clk   (clk),
        .reset (reset),
        .Addr  (Addr),
        .WE    (WE),
        .Din   (Din),
        .Dout  (Dout),
        .IRQ   (IRQ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called on a falling edge; the write lands on the following rising edge.
    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Addr = a;
        WE   = 1'b1;
        Din  = d;
        @(negedge clk);
        WE   = 1'b0;
        Din  = '0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d);
        Addr = a;
        #1;
        d = Dout;
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] v;
        for (int unsigned a = 0; a < 4; a++) begin
            rd(a * 4, v);
            n_cmp++;
            if (v !== 32'd0) begin
                n_err++;
                $display("FAIL reset_read addr=%0h got %h want 0", a * 4, v);
            end
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL reset_irq got %b want 0", IRQ);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc(2);
        wr(32'h4, 32'd100);
        wr(32'h0, 32'h9);
        cyc(62);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd40) begin
            n_err++;
            $display("FAIL midcount_value got %0d want 40", v);
        end
        #1;
        reset = 1'b0;
        #1;
        for (int unsigned a = 0; a < 3; a++) begin
            rd(a * 4, v);
            n_cmp++;
            if (v !== 32'd0) begin
                n_err++;
                $display("FAIL async_reset_read addr=%0h got %h want 0", a * 4, v);
            end
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset_irq got %b want 0", IRQ);
        end
        @(negedge clk);
        reset = 1'b1;
        cyc(3);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL post_reset_idle_count got %h want 0", v);
        end
    endtask

    task automatic test_oneshot;
        logic [31:0] v;
        logic        want;
        wr(32'h4, 32'd5);
        wr(32'h0, 32'h9);
        for (int i = 1; i <= 9; i++) begin
            cyc(1);
            want = (i >= 7);
            n_cmp++;
            if (IRQ !== want) begin
                n_err++;
                $display("FAIL oneshot_irq edge k+%0d got %b want %b", i, IRQ, want);
            end
        end
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'h8) begin
            n_err++;
            $display("FAIL oneshot_ctrl got %h want 8", v);
        end
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL oneshot_count got %h want 0", v);
        end
        wr(32'h0, 32'h8);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_ack got %b want 0", IRQ);
        end
        cyc(2);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL oneshot_ack_hold got %b want 0", IRQ);
        end
        wr(32'h0, 32'h0);
        cyc(2);
    endtask

    task automatic test_preset_zero;
        logic want;
        wr(32'h4, 32'd0);
        wr(32'h0, 32'h9);
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            want = (i >= 3);
            n_cmp++;
            if (IRQ !== want) begin
                n_err++;
                $display("FAIL preset0_irq edge k+%0d got %b want %b", i, IRQ, want);
            end
        end
        wr(32'h0, 32'h0);
        cyc(2);
    endtask

    task automatic test_freeze;
        logic [31:0] v;
        wr(32'h4, 32'd10);
        wr(32'h0, 32'h1);
        cyc(5);
        wr(32'h0, 32'h0);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd6) begin
            n_err++;
            $display("FAIL freeze_count got %0d want 6", v);
        end
        cyc(3);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd6) begin
            n_err++;
            $display("FAIL freeze_hold got %0d want 6", v);
        end
        wr(32'h0, 32'h1);
        cyc(1);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd6) begin
            n_err++;
            $display("FAIL restart_load_cycle got %0d want 6", v);
        end
        cyc(1);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd10) begin
            n_err++;
            $display("FAIL restart_reload got %0d want 10", v);
        end
        cyc(1);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd9) begin
            n_err++;
            $display("FAIL restart_decrement got %0d want 9", v);
        end
        wr(32'h0, 32'h0);
        cyc(2);
    endtask

    task automatic test_irq_masked;
        logic [31:0] v;
        wr(32'h4, 32'd2);
        wr(32'h0, 32'h1);
        for (int i = 1; i <= 7; i++) begin
            cyc(1);
            n_cmp++;
            if (IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL masked_irq edge k+%0d got %b want 0", i, IRQ);
            end
        end
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'h0) begin
            n_err++;
            $display("FAIL masked_ctrl got %h want 0", v);
        end
        wr(32'h0, 32'h8);
        for (int i = 0; i < 3; i++) begin
            n_cmp++;
            if (IRQ !== 1'b0) begin
                n_err++;
                $display("FAIL unmask_irq cycle %0d got %b want 0", i, IRQ);
            end
            cyc(1);
        end
        wr(32'h0, 32'h0);
        cyc(2);
    endtask

    task automatic test_reserved;
        logic [31:0] v;
        wr(32'h4, 32'd7);
        wr(32'h0, 32'h1);
        cyc(3);
        wr(32'h0, 32'h0);
        cyc(2);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd5) begin
            n_err++;
            $display("FAIL reserved_setup_count got %0d want 5", v);
        end
        wr(32'h8, 32'h1234);
        rd(32'h8, v);
        n_cmp++;
        if (v !== 32'd5) begin
            n_err++;
            $display("FAIL count_write_ignored got %h want 5", v);
        end
        wr(32'hC, 32'hFFFF_FFFF);
        rd(32'hC, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL reserved_read got %h want 0", v);
        end
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL reserved_ctrl_untouched got %h want 0", v);
        end
        rd(32'h7F1C, v);
        n_cmp++;
        if (v !== 32'd0) begin
            n_err++;
            $display("FAIL window_reserved_read got %h want 0", v);
        end
        rd(32'h7F14, v);
        n_cmp++;
        if (v !== 32'd7) begin
            n_err++;
            $display("FAIL window_preset_read got %h want 7", v);
        end
    endtask

    task automatic test_simultaneous;
        logic [31:0] v;
        wr(32'h4, 32'd1);
        wr(32'h0, 32'h9);
        cyc(3);
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL simul_int_irq got %b want 1", IRQ);
        end
        wr(32'h0, 32'h9);
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'h9) begin
            n_err++;
            $display("FAIL simul_cpu_wins got %h want 9", v);
        end
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL simul_irq_cleared got %b want 0", IRQ);
        end
        cyc(2);
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL simul_restart_early got %b want 0", IRQ);
        end
        cyc(1);
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL simul_restart_expiry got %b want 1", IRQ);
        end
        wr(32'h0, 32'h0);
        cyc(2);
    endtask

    task automatic test_mode;
        logic [31:0] v;
        logic        want;
`ifdef TC_AUTORELOAD_EN
        wr(32'h4, 32'd3);
        wr(32'h0, 32'hB);
        for (int i = 1; i <= 28; i++) begin
            cyc(1);
            want = (i == 5) || (i == 10) || (i == 18) || (i == 26);
            n_cmp++;
            if (IRQ !== want) begin
                n_err++;
                $display("FAIL autoreload_irq edge k+%0d got %b want %b", i, IRQ, want);
            end
            if (i == 7) begin
                Addr = 32'h4;
                Din  = 32'd6;
                WE   = 1'b1;
            end else if (i == 8) begin
                WE   = 1'b0;
                Din  = '0;
            end
        end
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'hB) begin
            n_err++;
            $display("FAIL autoreload_ctrl got %h want b", v);
        end
`else
        wr(32'h4, 32'd2);
        wr(32'h0, 32'hB);
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            want = (i >= 4);
            n_cmp++;
            if (IRQ !== want) begin
                n_err++;
                $display("FAIL mode01_oneshot_irq edge k+%0d got %b want %b", i, IRQ, want);
            end
        end
        rd(32'h0, v);
        n_cmp++;
        if (v !== 32'h8) begin
            n_err++;
            $display("FAIL mode01_ctrl got %h want 8", v);
        end
`endif
        wr(32'h0, 32'h0);
        cyc(3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b0;
        Addr  = '0;
        WE    = 1'b0;
        Din   = '0;
        cyc(2);
        test_reset;
        test_oneshot;
        test_preset_zero;
        test_freeze;
        test_irq_masked;
        test_reserved;
        test_simultaneous;
        test_mode;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/timer_counter.md
# timer_counter

Memory-mapped programmable down-counter occupying one timer window behind the CPU data bridge; it is the responder on the bridge's TC port (Addr/WE/Din/Dout). The CPU programs it through three word registers and it raises an interrupt request to CP0 when the count expires. Two instances sit behind the bridge, at 0x7F00–0x7F0B and 0x7F10–0x7F1B. Window decode is done by the bridge, and this block decodes only Addr[3:2].

## Interface
- No parameters.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset; clears all state.
- Addr  in  32  byte address from bridge; only [3:2] used.
- WE  in  1  word write strobe from bridge.
- Din  in  32  write data.
- Dout  out  32  read data, combinational from Addr[3:2].
- IRQ  out  1  interrupt request to CP0, registered.

## Operation
- Register map (Addr[3:2]):
  - 00 CTRL: [0] EN, [2:1] MODE, [3] IM. Bits [31:4] read 0.
  - 01 PRESET: 32-bit reload value.
  - 10 COUNT: read-only, and writes are ignored.
  - 11 reserved: reads 0, writes ignored.
- MODE values: 00 is one-shot and 01 is auto-reload. Values 1x behave as 00 and read back as written.
- State machine, reset state IDLE:
  - IDLE: if EN is set, go to LOAD.
  - LOAD: load COUNT from PRESET, then go to CNT.
  - CNT:
    - if EN is clear, go to IDLE with COUNT held;
    - else if COUNT > 1, decrement COUNT;
    - else (COUNT ≤ 1), set COUNT to 0, set irq_pending, and go to INT.
  - INT, MODE 00: hardware clears EN and goes to IDLE. irq_pending stays set until the CPU writes CTRL.
  - INT, MODE 01: go to LOAD. irq_pending clears after this single cycle, so the request is a one-cycle pulse per period.
- IRQ = IM & irq_pending, registered together with the state.
- Write side effects:
  - A CTRL write replaces [3:0] and clears irq_pending.
  - A PRESET write does not disturb a count in progress. It takes effect at the next LOAD.
- Simultaneous events: when a CPU CTRL write and the hardware EN-clear in INT fall in the same cycle, the CPU write wins. State still follows the INT transition.
- Clearing EN mid-count freezes COUNT. Setting EN again restarts from LOAD, not from the frozen value.
- Reset mid-operation returns the block to IDLE immediately (asynchronous). CTRL, PRESET, COUNT and irq_pending all become 0, so IRQ drops at once.

## Timing
- Reset values: CTRL=0, PRESET=0, COUNT=0, state IDLE, IRQ=0, and Dout=0 for every address.
- Reads are zero-latency: Dout is valid in the same cycle as Addr, as the bridge requires.
- Writes take effect at the clock edge that samples WE.
- Latency, one-shot: take edge k as the edge that writes EN=1 with PRESET=N≥1.
  - LOAD at k+1, COUNT=N at k+2.
  - INT and IRQ high after edge k+2+N.
  - N cycles are spent in CNT.
- PRESET=0 behaves as PRESET=1.
- Auto-reload period is N+2 cycles (INT, LOAD, N×CNT). IRQ is high exactly one cycle per period.
- No wrap-around: COUNT never decrements below 0.

## Configuration
- TC_AUTORELOAD_EN defined: MODE 01 auto-reload is implemented as above.
- TC_AUTORELOAD_EN undefined: MODE 01 and 1x behave as one-shot, and MODE bits are not stored (they read 0). The INT→LOAD path is absent.

## Test plan
- Reset asserted mid-count (PRESET=100, COUNT=40) -> COUNT, CTRL, PRESET, IRQ read 0 immediately, and state returns to IDLE.
- Write PRESET=5, then CTRL=0x9 at edge k -> IRQ rises after edge k+7 and stays high. CTRL reads 0x8 (EN cleared). Writing CTRL=0x8 drops IRQ the next cycle.
- PRESET=3, CTRL=0xB (auto-reload, IM) with TC_AUTORELOAD_EN -> IRQ pulses one cycle every 5 cycles. A PRESET write of 6 mid-period yields the current period unchanged and the following periods at 8 cycles.
- PRESET=10, EN=1; clear EN after 4 CNT cycles -> COUNT freezes at 6. Setting EN again reloads to 10.
- IM=0 one-shot expiry -> IRQ stays 0. Then writing IM=1 without the write clearing irq_pending is impossible, since the CTRL write clears it, so IRQ remains 0.
- Read Addr offset 0xC and write COUNT=0x1234 -> Dout=0, and COUNT is unchanged.
